// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle binary32 divider. A radix-2 restoring mantissa
// divider produces one quotient bit per clock. Special operands (zero,
// denormal, infinity, NaN) bypass the divider and finish one edge after
// accept. Both sides use valid/ready handshakes.
module fp_div_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int EXP_BIAS   = 127
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_nv,
    output logic                  out_dz
);
    localparam int QW    = MANT_WIDTH + 2;      // quotient / remainder width
    localparam int EW    = EXP_WIDTH + 2;       // signed exponent working width
    localparam int CNT_W = $clog2(QW);
    localparam int EXP_HI = DATA_WIDTH - 2;

    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2**EXP_WIDTH - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SPEC = 3'd1,
        ST_DIV  = 3'd2,
        ST_NORM = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                   state_r, state_n;
    logic [EXP_WIDTH-1:0]     a_exp_r, b_exp_r;
    logic [MANT_WIDTH-1:0]    a_frac_r, b_frac_r;
    logic                     sign_r;
    logic signed [EW-1:0]     exp_r;
    logic [QW-1:0]            rem_r, q_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [DATA_WIDTH-1:0]    out_result_r;
    logic                     out_nv_r, out_dz_r, out_valid_r, out_ready_r;

    logic                     in_spec_s, accept_s, ge_s;
    logic [QW-1:0]            divisor_s, rem_next_s;
    logic signed [EW-1:0]     exp_adj_s;
    logic [MANT_WIDTH-1:0]    mant_s;
    logic [DATA_WIDTH-1:0]    norm_result_s, spec_result_s;
    logic                     spec_nv_s, spec_dz_s;
    logic                     a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;

    assign accept_s  = in_valid & out_ready_r;
    assign in_spec_s = (in_numA[EXP_HI -: EXP_WIDTH] == '0) || (in_numA[EXP_HI -: EXP_WIDTH] == '1) ||
                       (in_numB[EXP_HI -: EXP_WIDTH] == '0) || (in_numB[EXP_HI -: EXP_WIDTH] == '1);
    assign divisor_s = {1'b0, 1'b1, b_frac_r};

    // One restoring-division step on the current partial remainder.
    always_comb begin
        ge_s       = (rem_r >= divisor_s);
        rem_next_s = rem_r << 1;
        if (ge_s) begin
            rem_next_s = (rem_r - divisor_s) << 1;
        end else begin
            rem_next_s = rem_r << 1;
        end
    end

    // Normalise the quotient, then saturate to inf or flush to zero out of range.
    always_comb begin
        exp_adj_s     = exp_r;
        mant_s        = q_r[QW-2:1];
        norm_result_s = '0;
        if (q_r[QW-1]) begin
            exp_adj_s = exp_r;
            mant_s    = q_r[QW-2:1];
        end else begin
            exp_adj_s = exp_r - EW'(1);
            mant_s    = q_r[QW-3:0];
        end
        if (exp_adj_s >= EXP_MAX) begin
            norm_result_s = {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else if (exp_adj_s <= EXP_ZERO) begin
            norm_result_s = {sign_r, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            norm_result_s = {sign_r, exp_adj_s[EXP_WIDTH-1:0], mant_s};
        end
    end

    // Classify latched operands and pick the special-case result (denormals count as zero).
    always_comb begin
        a_nan_s  = (a_exp_r == '1) && (a_frac_r != '0);
        a_inf_s  = (a_exp_r == '1) && (a_frac_r == '0);
        a_zero_s = (a_exp_r == '0);
        b_nan_s  = (b_exp_r == '1) && (b_frac_r != '0);
        b_inf_s  = (b_exp_r == '1) && (b_frac_r == '0);
        b_zero_s = (b_exp_r == '0);
        spec_result_s = '0;
        spec_nv_s     = 1'b0;
        spec_dz_s     = 1'b0;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_result_s = QNAN;
            spec_nv_s     = 1'b1;
        end else if (a_inf_s) begin
            spec_result_s = {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else if (b_zero_s) begin
            spec_result_s = {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            spec_dz_s     = 1'b1;
        end else begin
            // Remaining cases are 0/finite and finite/inf: signed zero.
            spec_result_s = {sign_r, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (in_spec_s) begin
                        state_n = ST_SPEC;
                    end else begin
                        state_n = ST_DIV;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SPEC: state_n = ST_DONE;
            ST_DIV: begin
                if (cnt_r == CNT_W'(QW-1)) begin
                    state_n = ST_NORM;
                end else begin
                    state_n = ST_DIV;
                end
            end
            ST_NORM: state_n = ST_DONE;
            ST_DONE: begin
                if (in_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Handshake outputs registered from the next state.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            out_ready_r <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
        end
    end

    // Operand capture, divider iterations and result registers.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            a_exp_r      <= '0;
            a_frac_r     <= '0;
            b_exp_r      <= '0;
            b_frac_r     <= '0;
            sign_r       <= 1'b0;
            exp_r        <= '0;
            rem_r        <= '0;
            q_r          <= '0;
            cnt_r        <= '0;
            out_result_r <= '0;
            out_nv_r     <= 1'b0;
            out_dz_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_exp_r  <= in_numA[EXP_HI -: EXP_WIDTH];
                        a_frac_r <= in_numA[MANT_WIDTH-1:0];
                        b_exp_r  <= in_numB[EXP_HI -: EXP_WIDTH];
                        b_frac_r <= in_numB[MANT_WIDTH-1:0];
                        sign_r   <= in_numA[DATA_WIDTH-1] ^ in_numB[DATA_WIDTH-1];
                        exp_r    <= EW'({2'b00, in_numA[EXP_HI -: EXP_WIDTH]}) -
                                    EW'({2'b00, in_numB[EXP_HI -: EXP_WIDTH]}) + EW'(EXP_BIAS);
                        rem_r    <= {1'b0, 1'b1, in_numA[MANT_WIDTH-1:0]};
                        q_r      <= '0;
                        cnt_r    <= '0;
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_next_s;
                    q_r   <= {q_r[QW-2:0], ge_s};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_NORM: begin
                    out_result_r <= norm_result_s;
                    out_nv_r     <= 1'b0;
                    out_dz_r     <= 1'b0;
                end
                ST_SPEC: begin
                    out_result_r <= spec_result_s;
                    out_nv_r     <= spec_nv_s;
                    out_dz_r     <= spec_dz_s;
                end
                ST_DONE: begin
                    out_result_r <= out_result_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign out_ready  = out_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_nv     = out_nv_r;
    assign out_dz     = out_dz_r;
endmodule
